// File: rtl/rf_write_scheduler.sv
// ============================================================================
// Module   : rf_write_scheduler
// Purpose  : Owns the register-file write port. Zero-clears every register
//            after reset, then arbitrates ALU and load write-back with a
//            contested-only round-robin, and tracks outstanding loads in a
//            per-register pending scoreboard for RAW hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_scheduler #(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_wd,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [DW-1:0]   ld_wd,
    output logic            ld_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_rd,
    output logic            rsv_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [DW-1:0]   rf_wd,
    output logic            init_done,
    output logic [NREG-1:0] pending,
    output logic            ld_orphan
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic            rr_ld;        // 1: load wins the next contested cycle
    logic            running;
    logic            alu_elig;
    logic            ld_elig;
    logic            grant_alu;
    logic            grant_ld;
    logic            rsv_take;
    logic [NREG-1:0] pending_nxt;

    // Eligibility and grant; an ALU write to a register with a load in flight is held (WAW)
    always_comb begin
        running   = !rst && (state == ST_RUN);
        alu_elig  = running && alu_valid && ((alu_rd == '0) || !pending[alu_rd]);
        ld_elig   = running && ld_valid;
        grant_alu = alu_elig && (!ld_elig || !rr_ld);
        grant_ld  = ld_elig && (!alu_elig || rr_ld);
    end

    // Handshakes, hazard and the write-port drive; everything is forced quiet during reset
    always_comb begin
        alu_ready = grant_alu;
        ld_ready  = grant_ld;
        rsv_ready = !rst && init_done && ((rsv_rd == '0) || !pending[rsv_rd]);
        rsv_take  = rsv_valid && rsv_ready && (rsv_rd != '0);
        hazard    = ((rs1 != '0) && pending[rs1]) || ((rs2 != '0) && pending[rs2]);
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        if (!rst && (state == ST_CLEAR)) begin
            rf_we = 1'b1;
            rf_wa = clr_cnt;
        end else if (grant_alu) begin
            rf_we = (alu_rd != '0);
            rf_wa = alu_rd;
            rf_wd = alu_wd;
        end else if (grant_ld) begin
            rf_we = (ld_rd != '0);
            rf_wa = ld_rd;
            rf_wd = ld_wd;
        end
    end

    // Scoreboard next value: a load grant clears its bit, a reservation sets one (set wins)
    always_comb begin
        pending_nxt = pending;
        if (grant_ld) begin
            pending_nxt[ld_rd] = 1'b0;
        end
        if (rsv_take) begin
            pending_nxt[rsv_rd] = 1'b1;
        end
    end

    // Sequencer: clear walk, then run-time pointer, scoreboard and orphan tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt   <= '0;
            rr_ld     <= 1'b0;
            init_done <= (INIT_CLEAR == 0);
            pending   <= '0;
            ld_orphan <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(NREG - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    if (alu_elig && ld_elig) begin
                        rr_ld <= !rr_ld;
                    end
                    if (grant_ld && (ld_rd != '0) && !pending[ld_rd]) begin
                        ld_orphan <= 1'b1;
                    end
                    pending <= pending_nxt;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_scheduler.sv
// ============================================================================
// Module   : tb_rf_write_scheduler
// Purpose  : Self-checking bench for rf_write_scheduler: directed scenarios
//            plus randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, rsv_valid;
    logic [4:0]  alu_rd, ld_rd, rsv_rd, rs1, rs2;
    logic [31:0] alu_wd, ld_wd;
    logic        alu_ready, ld_ready, rsv_ready, hazard, rf_we, init_done, ld_orphan;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd, pending;

    int errors = 0;
    int checks = 0;

    rf_write_scheduler dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_wd(ld_wd), .ld_ready(ld_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .init_done(init_done), .pending(pending), .ld_orphan(ld_orphan)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit m_clearing;      // still walking the zero-clear
    int m_idx;           // register being cleared
    bit m_pend[32];      // loads in flight per register
    bit m_pref_ld;       // load is preferred when both compete
    bit m_orph;
    bit m_init;

    task automatic mdl_reset();
        m_clearing = 1'b1;
        m_idx      = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_pref_ld  = 1'b0;
        m_orph     = 1'b0;
        m_init     = 1'b0;
    endtask

    function automatic bit mdl_alu_ok();
        return !rst && !m_clearing && alu_valid && (alu_rd == 0 || !m_pend[alu_rd]);
    endfunction

    function automatic bit mdl_ld_ok();
        return !rst && !m_clearing && ld_valid;
    endfunction

    // 0 = nobody, 1 = ALU, 2 = load
    function automatic int mdl_winner();
        if (mdl_alu_ok() && mdl_ld_ok()) return m_pref_ld ? 2 : 1;
        if (mdl_alu_ok()) return 1;
        if (mdl_ld_ok()) return 2;
        return 0;
    endfunction

    function automatic bit mdl_rsv_ok();
        return !rst && m_init && (rsv_rd == 0 || !m_pend[rsv_rd]);
    endfunction

    function automatic logic [31:0] mdl_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic mdl_edge();
        int w;
        bit contested, rsv_ok;
        if (rst) begin
            mdl_reset();
        end else if (m_clearing) begin
            if (m_idx == 31) begin
                m_clearing = 1'b0;
                m_init     = 1'b1;
            end else begin
                m_idx++;
            end
        end else begin
            w         = mdl_winner();
            contested = mdl_alu_ok() && mdl_ld_ok();
            rsv_ok    = rsv_valid && mdl_rsv_ok();
            if (w == 2) begin
                if (ld_rd != 0 && !m_pend[ld_rd]) m_orph = 1'b1;
                m_pend[ld_rd] = 1'b0;
            end
            if (rsv_ok && rsv_rd != 0) m_pend[rsv_rd] = 1'b1;
            if (contested) m_pref_ld = !m_pref_ld;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        ld_valid  = 0; ld_rd  = 0; ld_wd  = 0;
        rsv_valid = 0; rsv_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        mdl_reset();
        idle_inputs();
        alu_valid = 1; ld_valid = 1; rsv_valid = 1; alu_rd = 3; ld_rd = 4; rsv_rd = 5;
        tick(); tick();
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we act=%0b exp=0", rf_we); end
        checks++; if ({alu_ready, ld_ready, rsv_ready} !== 3'b000) begin errors++; $display("FAIL reset_readys act=%b exp=000", {alu_ready, ld_ready, rsv_ready}); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init act=%0b exp=0", init_done); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending act=%h exp=0", pending); end
        checks++; if (ld_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan act=%0b exp=0", ld_orphan); end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++; if (rf_we !== 1'b1 || rf_wa !== 5'(i) || rf_wd !== 32'h0) begin
                errors++; $display("FAIL clear_write[%0d] act=we%0b wa%0d wd%h exp=we1 wa%0d wd0", i, rf_we, rf_wa, rf_wd, i);
            end
            checks++; if ({alu_ready, ld_ready, rsv_ready, init_done} !== 4'b0000) begin
                errors++; $display("FAIL clear_quiet[%0d] act=%b exp=0000", i, {alu_ready, ld_ready, rsv_ready, init_done});
            end
            tick();
        end
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise act=%0b exp=1", init_done); end
        idle_inputs();
    endtask

    task automatic test_alu_single();
        idle_inputs();
        alu_valid = 1; alu_rd = 5; alu_wd = 32'h1234;
        #1;
        checks++; if ({alu_ready, rf_we} !== 2'b11 || rf_wa !== 5'd5 || rf_wd !== 32'h1234) begin
            errors++; $display("FAIL alu_single act=rdy%0b we%0b wa%0d wd%h exp=rdy1 we1 wa5 wd1234", alu_ready, rf_we, rf_wa, rf_wd);
        end
        tick();
        alu_rd = 0; alu_wd = 32'hDEAD;
        #1;
        checks++; if ({alu_ready, rf_we} !== 2'b10) begin
            errors++; $display("FAIL alu_x0 act=rdy%0b we%0b exp=rdy1 we0", alu_ready, rf_we);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_raw_hazard();
        idle_inputs();
        rsv_valid = 1; rsv_rd = 7; rs1 = 7;
        #1;
        checks++; if ({rsv_ready, hazard} !== 2'b10) begin errors++; $display("FAIL rsv7_accept act=%b exp=10", {rsv_ready, hazard}); end
        tick();
        rsv_valid = 0; alu_valid = 1; alu_rd = 7; alu_wd = 32'hA7A7;
        #1;
        checks++; if (pending[7] !== 1'b1 || hazard !== 1'b1) begin errors++; $display("FAIL pend7_set act=p%0b hz%0b exp=p1 hz1", pending[7], hazard); end
        checks++; if ({alu_ready, rf_we} !== 2'b00) begin errors++; $display("FAIL alu_waw_stall act=%b exp=00", {alu_ready, rf_we}); end
        tick();
        ld_valid = 1; ld_rd = 7; ld_wd = 32'h7777;
        #1;
        checks++; if ({ld_ready, alu_ready, hazard} !== 3'b101 || rf_wa !== 5'd7 || rf_wd !== 32'h7777) begin
            errors++; $display("FAIL ld7_grant act=lr%0b ar%0b hz%0b wa%0d wd%h exp=lr1 ar0 hz1 wa7 wd7777", ld_ready, alu_ready, hazard, rf_wa, rf_wd);
        end
        tick();
        ld_valid = 0;
        #1;
        checks++; if (pending[7] !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL pend7_clear act=p%0b hz%0b exp=p0 hz0", pending[7], hazard); end
        checks++; if (alu_ready !== 1'b1 || rf_wd !== 32'hA7A7) begin errors++; $display("FAIL alu_after_ld act=rdy%0b wd%h exp=rdy1 wdA7A7", alu_ready, rf_wd); end
        tick();
        idle_inputs();
    endtask

    task automatic test_orphan_setwins();
        idle_inputs();
        #1;
        checks++; if (ld_orphan !== 1'b0) begin errors++; $display("FAIL orphan_pre act=%0b exp=0", ld_orphan); end
        ld_valid = 1; ld_rd = 12; ld_wd = 32'hC0C0;
        #1;
        checks++; if ({ld_ready, rf_we} !== 2'b11 || rf_wa !== 5'd12) begin errors++; $display("FAIL orphan_write act=rdy%0b we%0b wa%0d exp=rdy1 we1 wa12", ld_ready, rf_we, rf_wa); end
        tick();
        ld_valid = 0;
        tick(); tick();
        #1;
        checks++; if (ld_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky act=%0b exp=1", ld_orphan); end
        rsv_valid = 1; rsv_rd = 0;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv_x0_ready act=%0b exp=1", rsv_ready); end
        tick();
        rsv_rd = 9; ld_valid = 1; ld_rd = 9; ld_wd = 32'h9999;
        #1;
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL rsv_x0_nopend act=%0b exp=0", pending[0]); end
        checks++; if ({rsv_ready, ld_ready} !== 2'b11) begin errors++; $display("FAIL setwins_hs act=%b exp=11", {rsv_ready, ld_ready}); end
        tick();
        #1;
        checks++; if (pending[9] !== 1'b1) begin errors++; $display("FAIL setwins_pend9 act=%0b exp=1", pending[9]); end
        checks++; if ({rsv_ready, ld_ready} !== 2'b01) begin errors++; $display("FAIL rsv9_blocked act=%b exp=01", {rsv_ready, ld_ready}); end
        tick();
        #1;
        checks++; if (pending[9] !== 1'b0) begin errors++; $display("FAIL ld9_clear act=%0b exp=0", pending[9]); end
        idle_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        bit exp_alu;
        idle_inputs();
        rsv_valid = 1; rsv_rd = 4;
        tick();
        rsv_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_wd = 32'h3333;
        ld_valid  = 1; ld_rd  = 4; ld_wd  = 32'h4444;
        for (int i = 0; i < 4; i++) begin
            exp_alu = (i % 2 == 0);
            #1;
            checks++; if ({alu_ready, ld_ready} !== {exp_alu, !exp_alu} || rf_wa !== (exp_alu ? 5'd3 : 5'd4)) begin
                errors++; $display("FAIL rr_grant[%0d] act=ar%0b lr%0b wa%0d exp=ar%0b lr%0b", i, alu_ready, ld_ready, rf_wa, exp_alu, !exp_alu);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_midclear();
        idle_inputs();
        rst = 1'b1; mdl_reset();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd10) begin errors++; $display("FAIL midclear_pos act=we%0b wa%0d exp=we1 wa10", rf_we, rf_wa); end
        rst = 1'b1; mdl_reset();
        #1;
        checks++; if ({rf_we, init_done} !== 2'b00) begin errors++; $display("FAIL midclear_abort act=%b exp=00", {rf_we, init_done}); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            checks++; if (rf_we !== 1'b1 || rf_wa !== 5'(i) || init_done !== 1'b0) begin
                errors++; $display("FAIL reclear[%0d] act=we%0b wa%0d id%0b exp=we1 wa%0d id0", i, rf_we, rf_wa, init_done, i);
            end
            tick();
        end
        #1;
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reclear_done act=%0b exp=1", init_done); end
    endtask

    task automatic test_random();
        int w;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        bit e_we;
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            alu_valid = $urandom_range(0, 1); alu_rd = 5'($urandom_range(0, 7)); alu_wd = $urandom;
            ld_valid  = $urandom_range(0, 1); ld_rd  = 5'($urandom_range(0, 7)); ld_wd  = $urandom;
            rsv_valid = $urandom_range(0, 1); rsv_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            if (rst) mdl_reset();
            #1;
            w = mdl_winner();
            e_we = 0; e_wa = 0; e_wd = 0;
            if (!rst && m_clearing) begin e_we = 1; e_wa = 5'(m_idx); end
            else if (w == 1) begin e_we = (alu_rd != 0); e_wa = alu_rd; e_wd = alu_wd; end
            else if (w == 2) begin e_we = (ld_rd != 0); e_wa = ld_rd; e_wd = ld_wd; end
            checks++; if (alu_ready !== (w == 1)) begin errors++; $display("FAIL rnd_alu_ready[%0d] act=%0b exp=%0b", n, alu_ready, w == 1); end
            checks++; if (ld_ready !== (w == 2)) begin errors++; $display("FAIL rnd_ld_ready[%0d] act=%0b exp=%0b", n, ld_ready, w == 2); end
            checks++; if (rsv_ready !== mdl_rsv_ok()) begin errors++; $display("FAIL rnd_rsv_ready[%0d] act=%0b exp=%0b", n, rsv_ready, mdl_rsv_ok()); end
            checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd_we[%0d] act=%0b exp=%0b", n, rf_we, e_we); end
            if (!rst) begin
                checks++; if (rf_wa !== e_wa || rf_wd !== e_wd) begin errors++; $display("FAIL rnd_wa_wd[%0d] act=%0d/%h exp=%0d/%h", n, rf_wa, rf_wd, e_wa, e_wd); end
            end
            checks++; if (hazard !== ((rs1 != 0 && m_pend[rs1]) || (rs2 != 0 && m_pend[rs2]))) begin errors++; $display("FAIL rnd_hazard[%0d] act=%0b", n, hazard); end
            checks++; if (pending !== mdl_pend_vec()) begin errors++; $display("FAIL rnd_pending[%0d] act=%h exp=%h", n, pending, mdl_pend_vec()); end
            checks++; if (ld_orphan !== m_orph) begin errors++; $display("FAIL rnd_orphan[%0d] act=%0b exp=%0b", n, ld_orphan, m_orph); end
            checks++; if (init_done !== m_init) begin errors++; $display("FAIL rnd_init[%0d] act=%0b exp=%0b", n, init_done, m_init); end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_raw_hazard();
        test_orphan_setwins();
        test_round_robin();
        test_reset_midclear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
